multiplicador: RTL and testbench
================================

// Module: multiplicador
// PURPOSE
//   Sequential radix-2 shift-and-add multiply-accumulate: result = MD_in*MR_in + AD_in.
//   Inverse of the divider: feeding it (quotient, divisor, remainder) rebuilds the dividend.
//   Shares the divider's init/ready handshake. Used by the firmware-visible math peripheral for
//   quotient*divisor+remainder checks and general 32x32 products.
// PARAMETERS
//   WIDTH    32   operand width; result is 2*WIDTH
// PORTS
//   clk      in   1        single clock; all state changes on posedge
//   reset    in   1        asynchronous, active-low reset
//   MD_in    in   WIDTH    multiplicand
//   MR_in    in   WIDTH    multiplier
//   AD_in    in   WIDTH    addend, zero-extended
//   init     in   1        start request, sampled only in IDLE
//   ready    out  1        result valid; held until the next accepted init
//   busy     out  1        operation in progress
//   result   out  2*WIDTH  MD*MR+AD
//   ovf      out  1        |result[2W-1:W], so the result does not fit WIDTH bits
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; ready=0, busy=0, result=0, ovf=0; internal regs cleared.
//   States: IDLE -> CALC -> ADDC -> DONE -> IDLE.
//   IDLE: init=1 at an edge captures MD/MR/AD, sets acc=0, count=WIDTH, busy=1, ready=0,
//     goes to CALC. init=0 holds every output.
//   CALC (exactly WIDTH cycles): {c,hi} = acc_hi + (MR[0] ? MD : 0) at WIDTH+1 bits;
//     acc = {c,hi,acc_lo} >> 1; MR >>= 1; count--. Moves to ADDC on the edge where count
//     reaches 0.
//   ADDC: acc += {W'b0, AD}. This cannot overflow 2W bits because (2^W-1)^2 + 2^W-1 < 2^2W.
//   DONE: result=acc, ovf=|acc[2W-1:W], ready=1, busy=0, then go to IDLE.
//   Latency: init sampled at edge k, so ready and result are valid after edge k+WIDTH+2
//     (34 for W=32).
//   result/ovf change only in DONE or on reset; they stay stable while the next op runs.
//   init while busy is ignored and not queued. init held high stays level-sensitive: a new op
//     starts on the first IDLE edge after DONE, which clears ready again.
//   Operand inputs are don't-care after the capture edge.
//   Zero operands still take the full latency; there is no early termination.
//   Reset mid-operation aborts immediately. No partial result is exposed.
//   No combinational path from any input to any output.
// STRUCTURE
//   Shared package divmul_pkg: state localparams (IDLE=0, CALC=1, ADDC=2, DONE=3), default
//     WIDTH, counter width $clog2(WIDTH)+1. The divider reuses the same package.
//   One sub-module, mul_step: combinational conditional add plus right shift of
//     {acc, MR}, WIDTH-parameterized. The FSM, counter and output regs stay in multiplicador.
// TESTING
//   1 7*3+1: init pulse -> ready after 34 cycles, result=0x16, ovf=0, busy low.
//   2 MD=MR=AD=0xFFFFFFFF -> result=0xFFFFFFFF_00000000, ovf=1.
//   3 MD=0, MR=0x1234, AD=5 -> result=5 with full 34-cycle latency. Swapping operands
//     gives the same result.
//   4 Divider round trip: 100/7 -> q=14, r=2. Then 14*7+2 -> 100. Repeat 1000 random
//     pairs (DR!=0) and check result==DV and ovf=0.
//   5 init re-pulsed at cycles 5 and 20 of an op -> ignored; first result intact;
//     back-to-back ops with init held high give ready pulses 35 cycles apart.
//   6 reset asserted at cycle 10 of an op -> outputs 0 asynchronously; a new op after
//     release is correct.

Source files
------------

// File: rtl/divmul_pkg.sv
// Shared definitions for the sequential divide / multiply-accumulate units:
// FSM state encoding, default operand width and counter sizing.
package divmul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADDC = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/multiplicador_if.sv
// Operand/handshake bundle for the multiply-accumulate unit; the master
// drives operands and init, the slave returns ready/busy/result/ovf.
interface multiplicador_if #(
  parameter int WIDTH = divmul_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0]   MD_in;
  logic [WIDTH-1:0]   MR_in;
  logic [WIDTH-1:0]   AD_in;
  logic               init;
  logic               ready;
  logic               busy;
  logic [2*WIDTH-1:0] result;
  logic               ovf;

  modport master (
    output MD_in, MR_in, AD_in, init,
    input  ready, busy, result, ovf
  );

  modport slave (
    input  MD_in, MR_in, AD_in, init,
    output ready, busy, result, ovf
  );
endinterface

// File: rtl/multiplicador_mul_step.sv
// One radix-2 shift-and-add step: conditionally add MD into the upper half of
// the accumulator, then shift {carry, acc} and the multiplier right by one.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_acc_hi,
  input  logic [WIDTH-2:0]   i_acc_lo,  // acc[WIDTH-1:1]; bit 0 falls off the shift
  input  logic [WIDTH-1:0]   i_mr,
  input  logic [WIDTH-1:0]   i_md,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_mr
);
  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_acc_hi} + {1'b0, (i_mr[0] ? i_md : '0)};
  assign o_acc = {w_sum, i_acc_lo};
  assign o_mr  = {1'b0, i_mr[WIDTH-1:1]};
endmodule

// File: rtl/multiplicador.sv
// Sequential multiply-accumulate: result = MD*MR + AD over WIDTH+2 cycles,
// using the same init/ready handshake as the divider.
module multiplicador
  import divmul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  multiplicador_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_md;
  logic [WIDTH-1:0]   r_mr;
  logic [WIDTH-1:0]   r_ad;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_ready;
  logic               r_busy;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ovf;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_mr_nxt;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .i_acc_hi (r_acc[2*WIDTH-1:WIDTH]),
    .i_acc_lo (r_acc[WIDTH-1:1]),
    .i_mr     (r_mr),
    .i_md     (r_md),
    .o_acc    (w_acc_nxt),
    .o_mr     (w_mr_nxt)
  );

  // NOTE: every register here is state, so only non-blocking assignments are
  // used; all of them, operand copies included, are cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_md     <= '0;
      r_mr     <= '0;
      r_ad     <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.init) begin
            r_md    <= bus.MD_in;
            r_mr    <= bus.MR_in;
            r_ad    <= bus.AD_in;
            r_acc   <= '0;
            r_count <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc   <= w_acc_nxt;
          r_mr    <= w_mr_nxt;
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) r_state <= ADDC;
        end
        ADDC: begin
          // Cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W).
          r_acc   <= r_acc + {{WIDTH{1'b0}}, r_ad};
          r_state <= DONE;
        end
        DONE: begin
          r_result <= r_acc;
          r_ovf    <= |r_acc[2*WIDTH-1:WIDTH];
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_multiplicador.sv
// Directed + randomized bench for multiplicador: expected results are pushed
// to a scoreboard when an op is launched and popped when ready rises.
module tb_multiplicador;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic [64:0] sb[$];  // {ovf, result}

  multiplicador_if #(.WIDTH(W)) bus ();
  multiplicador #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] md, input logic [31:0] mr,
                          input logic [31:0] ad, output int cap);
    logic [63:0] e;
    e = {32'b0, md} * {32'b0, mr} + {32'b0, ad};
    @(negedge clk);
    bus.MD_in = md; bus.MR_in = mr; bus.AD_in = ad; bus.init = 1'b1;
    sb.push_back({|e[63:32], e});
    @(posedge clk); #1;
    cap = cyc;
    @(negedge clk);
    bus.init = 1'b0;
    bus.MD_in = $urandom; bus.MR_in = $urandom; bus.AD_in = $urandom;
  endtask

  task automatic wait_ready(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("ready_timeout", 64'(bus.ready), 64'd1);
  endtask

  task automatic compare_sb(input string tag);
    logic [64:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, bus.result, e[63:0]);
      check({tag, "_ovf"}, 64'(bus.ovf), 64'(e[64]));
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic finish_op(input string tag, input int cap, input bit chk_lat);
    int t;
    wait_ready(t);
    if (chk_lat) check({tag, "_latency"}, 64'(t - cap), 64'd34);
    compare_sb(tag);
  endtask

  initial begin
    int cap, t1, t2;
    logic [31:0] dv, dr, q, r;

    reset = 1'b0;
    bus.init = 1'b0; bus.MD_in = '0; bus.MR_in = '0; bus.AD_in = '0;
    #12;
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 7*3+1 with latency, busy/ready during the op and hold afterwards
    start_op(32'd7, 32'd3, 32'd1, cap);
    check("t1_busy_run", 64'(bus.busy), 64'd1);
    check("t1_ready_run", 64'(bus.ready), 64'd0);
    finish_op("t1", cap, 1'b1);
    check("t1_const", bus.result, 64'h16);
    repeat (5) @(posedge clk);
    #1;
    check("t1_ready_held", 64'(bus.ready), 64'd1);
    check("t1_result_held", bus.result, 64'h16);

    // all-ones operands; previous result stays visible while running
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cap);
    repeat (10) @(posedge clk);
    #1;
    check("t2_result_stable", bus.result, 64'h16);
    finish_op("t2", cap, 1'b1);
    check("t2_const", bus.result, 64'hFFFF_FFFF_0000_0000);
    check("t2_ovf_const", 64'(bus.ovf), 64'd1);

    // zero operand, both orders, full latency
    start_op(32'd0, 32'h1234, 32'd5, cap);
    finish_op("t3a", cap, 1'b1);
    check("t3a_const", bus.result, 64'd5);
    start_op(32'h1234, 32'd0, 32'd5, cap);
    finish_op("t3b", cap, 1'b1);
    check("t3b_const", bus.result, 64'd5);

    // divider round trip: q*dr + r rebuilds dv
    q = 32'd100 / 32'd7; r = 32'd100 % 32'd7;
    start_op(q, 32'd7, r, cap);
    finish_op("t4", cap, 1'b1);
    check("t4_const", bus.result, 64'd100);
    for (int i = 0; i < 1000; i++) begin
      dv = $urandom;
      dr = $urandom;
      if (dr == 0) dr = 32'd1;
      if (i % 4 == 0) dr = dr & 32'hFF;
      if (dr == 0) dr = 32'd3;
      q = dv / dr; r = dv % dr;
      start_op(q, dr, r, cap);
      finish_op("rt", cap, 1'b0);
      check("rt_dv", bus.result, {32'b0, dv});
    end

    // init re-pulsed at cycles 5 and 20 of a running op
    start_op(32'h0001_0003, 32'h0000_0F0F, 32'd9, cap);
    repeat (4) @(negedge clk);
    bus.MD_in = 32'hDEAD_BEEF; bus.MR_in = 32'h1111; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (14) @(negedge clk);
    bus.MD_in = 32'hCAFE; bus.MR_in = 32'h2222; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    finish_op("t5", cap, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_queued_ready", 64'(bus.ready), 64'd1);
    check("t5_no_queued_busy", 64'(bus.busy), 64'd0);

    // back-to-back ops with init held high
    @(negedge clk);
    bus.MD_in = 32'd1000; bus.MR_in = 32'd2000; bus.AD_in = 32'd3; bus.init = 1'b1;
    sb.push_back({1'b0, 64'd2_000_003});
    sb.push_back({1'b0, 64'd2_000_003});
    wait_ready(t1);
    compare_sb("b2b_first");
    @(posedge clk); #1;
    check("b2b_ready_cleared", 64'(bus.ready), 64'd0);
    wait_ready(t2);
    @(negedge clk);
    bus.init = 1'b0;
    check("b2b_spacing", 64'(t2 - t1), 64'd35);
    compare_sb("b2b_second");

    // asynchronous reset in the middle of an op
    start_op(32'd5, 32'd6, 32'd7, cap);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_result", bus.result, 64'd0);
    check("t6_rst_ready", 64'(bus.ready), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_ovf", 64'(bus.ovf), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b1;
    start_op(32'd123, 32'd456, 32'd789, cap);
    finish_op("t6_after", cap, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
